data_memory: RTL and testbench
==============================

// Module: data_memory
//
// PURPOSE
// Multi-cycle data memory, the responder side of the CPU's BUSYWAIT stall handshake.
// CPU control raises READ or WRITE. This block asserts BUSYWAIT to stall the PC and
// register-file writeback. It performs the access after LATENCY cycles, then drops
// BUSYWAIT for one cycle so the CPU advances and latches READDATA.
//
// PARAMETERS
// ADDR_WIDTH  8  address width; depth = 2**ADDR_WIDTH words
// DATA_WIDTH  8  word width
// LATENCY     5  cycles spent in BUSY state per access; legal range 1..15
//
// PORTS
// CLK        in   1           clock; all state updates on posedge
// RESET      in   1           synchronous, active-high reset
// READ       in   1           read request from CPU control
// WRITE      in   1           write request from CPU control
// ADDRESS    in   ADDR_WIDTH  word address (ALU result)
// WRITEDATA  in   DATA_WIDTH  store data (register-file OUT1)
// READDATA   out  DATA_WIDTH  load data; registered
// BUSYWAIT   out  1           stall to CPU; high while access is pending
//
// BEHAVIOUR
// - States: IDLE, BUSY, DONE. 4-bit down-counter cnt.
// - Reset (RESET=1 at posedge): state<=IDLE, cnt<=0, READDATA<=0.
//   While RESET=1, BUSYWAIT is forced to 0. Memory array contents are not cleared.
// - IDLE:
//   - BUSYWAIT = READ|WRITE, combinational, so the stall starts in the request cycle.
//   - At posedge with READ|WRITE: latch ADDRESS, WRITEDATA and op; cnt<=LATENCY-1; go to BUSY.
// - BUSY:
//   - BUSYWAIT=1.
//   - At posedge with cnt!=0: cnt<=cnt-1.
//   - At posedge with cnt==0: perform the latched op and go to DONE.
//     - Write: mem[addr]<=data.
//     - Read: READDATA<=mem[addr].
//   - READ/WRITE/ADDRESS changes during BUSY are ignored.
// - DONE:
//   - BUSYWAIT=0 for exactly one cycle; the CPU advances at the next posedge.
//   - Requests in DONE are ignored (they belong to the completing instruction).
//   - Next posedge: go to IDLE.
// - Timing: BUSYWAIT is high for LATENCY+1 cycles, counting the request cycle.
//   READDATA is valid from the completing edge and held until the next read completes.
// - READ and WRITE both high: treated as WRITE; READDATA unchanged.
// - A write leaves READDATA unchanged.
// - Reset mid-access: the access is aborted and any pending write is discarded. The
//   memory array is untouched. The next cycle is IDLE with BUSYWAIT=0 if no request.
// - Back-to-back requests: each costs LATENCY+2 cycles (IDLE->BUSY->DONE->IDLE).
// - ADDRESS indexes 0..2**ADDR_WIDTH-1 directly; no wrap or bounds logic is needed.
// - Uninitialised location read returns X; the bench preloads before checking.
//
// TESTING
// 1. Reset: RESET=1 for 2 cycles with READ=1 -> BUSYWAIT=0, READDATA=8'h00;
//    state is IDLE after RESET falls.
// 2. Write then read: WRITE=1 with ADDRESS=8'h2A, WRITEDATA=8'hC5.
//    -> BUSYWAIT high for 6 cycles, then low for 1 cycle.
//    Then READ=1 with ADDRESS=8'h2A -> READDATA=8'hC5 on the completing edge,
//    with BUSYWAIT low that cycle.
// 3. Latency sweep: LATENCY=1 and LATENCY=15 -> BUSYWAIT high for 2 and 16 cycles;
//    the count is exact.
// 4. Input churn: change ADDRESS to 8'hFF and WRITEDATA to 8'h00 mid-BUSY
//    -> the write lands at 8'h2A with 8'hC5; mem[8'hFF] is unchanged.
// 5. Reset mid-write to 8'h10 (old value 8'h33) at the 3rd BUSY cycle
//    -> a later read of 8'h10 returns 8'h33; BUSYWAIT=0 after reset.
// 6. READ=WRITE=1, ADDRESS=8'h05, WRITEDATA=8'h7E -> mem[5]=8'h7E;
//    READDATA holds its previous value.

Source files
------------

// File: rtl/data_memory.sv
// Multi-cycle data memory answering the CPU's BUSYWAIT stall handshake.
// Each access stalls for LATENCY cycles in BUSY, then releases the CPU for one DONE cycle.
module data_memory #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LATENCY    = 5
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDRESS,
   input  logic [DATA_WIDTH-1:0] WRITEDATA,
   output logic [DATA_WIDTH-1:0] READDATA,
   output logic                  BUSYWAIT
);

   localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    is_wr_q, is_wr_d;
   logic                    mem_we;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // Next-state, access strobes and the stall output
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      is_wr_d  = is_wr_q;
      rdata_d  = rdata_q;
      mem_we   = 1'b0;
      BUSYWAIT = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Stall is raised in the request cycle itself
            BUSYWAIT = READ | WRITE;
            if (READ | WRITE) begin
               addr_d  = ADDRESS;
               wdata_d = WRITEDATA;
               is_wr_d = WRITE;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            BUSYWAIT = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (is_wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d = mem[addr_q];
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (RESET) begin
         BUSYWAIT = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Request capture registers; only consumed in BUSY, so no reset is needed
   always_ff @(posedge CLK) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
   end

   // Array is never cleared; a reset on the completing edge drops the write
   always_ff @(posedge CLK) begin
      if (mem_we && !RESET) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign READDATA = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory: a reference memory model predicts every
// completion, a monitor checks READDATA and stall length whenever BUSYWAIT releases.
module tb_data_memory;

   logic       clk = 1'b0;
   logic       rst;
   logic       rd, wr;
   logic [7:0] addr, wdata;
   logic [7:0] rdata;
   logic       bw;

   logic       sw_wr;
   logic [7:0] rdata1, rdata15;
   logic       bw1, bw15;

   localparam int LAT = 5;

   typedef struct {
      logic [7:0] rd;
      int         busy;
      string      name;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model [int];
   logic [7:0] exp_rd;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(LAT)) dut (
      .CLK(clk), .RESET(rst), .READ(rd), .WRITE(wr), .ADDRESS(addr),
      .WRITEDATA(wdata), .READDATA(rdata), .BUSYWAIT(bw)
   );

   data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(1)) u_l1 (
      .CLK(clk), .RESET(rst), .READ(1'b0), .WRITE(sw_wr), .ADDRESS(addr),
      .WRITEDATA(wdata), .READDATA(rdata1), .BUSYWAIT(bw1)
   );

   data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(15)) u_l15 (
      .CLK(clk), .RESET(rst), .READ(1'b0), .WRITE(sw_wr), .ADDRESS(addr),
      .WRITEDATA(wdata), .READDATA(rdata15), .BUSYWAIT(bw15)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: counts stall cycles and checks each completion against the scoreboard
   int run = 0;
   always @(negedge clk) begin
      if (rst) begin
         run = 0;
      end else if (bw) begin
         run++;
      end else if (run > 0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got a completion expected none");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_readdata"}, 32'(rdata), 32'(e.rd));
            chk({e.name, "_busy_cycles"}, 32'(run), 32'(e.busy));
         end
         run = 0;
      end
   end

   // One CPU access; predicts the result from the model before driving it
   task automatic access(input bit r, input bit w, input logic [7:0] a,
                         input logic [7:0] d, input bit churn, input string nm);
      exp_t e;
      int   n;
      if (w) model[int'(a)] = d;
      else   exp_rd = model[int'(a)];
      e.rd   = exp_rd;
      e.busy = LAT + 1;
      e.name = nm;
      sb.push_back(e);

      rd = r; wr = w; addr = a; wdata = d;
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
      if (churn) begin
         rd    = 1'b1;
         wr    = 1'($urandom_range(0, 1));
         addr  = 8'hFF;
         wdata = 8'h00;
      end
      n = 0;
      while (bw && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got BUSYWAIT stuck high expected release", nm);
      end
      rd = 1'b0; wr = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int n1, n15, waitn;
      logic [7:0] a;

      rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 8'h00; wdata = 8'h00; sw_wr = 1'b0;
      exp_rd = 8'h00;

      // Reset held with a pending read request
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busywait", 32'(bw), 32'(0));
      chk("reset_readdata", 32'(rdata), 32'(0));
      rst = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", 32'(bw), 32'(0));

      // Directed: preload, write with input churn, read back
      access(1'b0, 1'b1, 8'hFF, 8'h5A, 1'b0, "preload_ff");
      access(1'b0, 1'b1, 8'h2A, 8'hC5, 1'b1, "write_2a_churn");
      access(1'b1, 1'b0, 8'h2A, 8'h00, 1'b0, "read_2a");
      access(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, "read_ff_untouched");

      // Both strobes high acts as a write and leaves READDATA alone
      access(1'b1, 1'b1, 8'h05, 8'h7E, 1'b0, "rdwr_05");
      access(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, "read_05");

      // Reset during the 3rd BUSY cycle of a write to 8'h10
      access(1'b0, 1'b1, 8'h10, 8'h33, 1'b0, "preload_10");
      wr = 1'b1; addr = 8'h10; wdata = 8'hAA;
      @(posedge clk); #1;
      wr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midreset_busywait", 32'(bw), 32'(0));
      chk("midreset_readdata", 32'(rdata), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("after_midreset_busywait", 32'(bw), 32'(0));
      exp_rd = 8'h00;
      access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, "read_10_aborted");

      // Randomized mix over a small address window so reads hit written data
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom_range(0, 15));
         if (!model.exists(int'(a)) || $urandom_range(0, 1) == 0)
            access(1'($urandom_range(0, 3) == 0), 1'b1, a, 8'($urandom),
                   1'($urandom_range(0, 1)), "rand_wr");
         else
            access(1'b1, 1'b0, a, 8'($urandom), 1'($urandom_range(0, 1)), "rand_rd");
      end

      // Latency sweep on the LATENCY=1 and LATENCY=15 instances
      sw_wr = 1'b1; addr = 8'h40; wdata = 8'h11;
      @(negedge clk);
      n1 = int'(bw1); n15 = int'(bw15);
      @(posedge clk); #1;
      sw_wr = 1'b0;
      repeat (30) begin
         @(negedge clk);
         n1 += int'(bw1);
         n15 += int'(bw15);
      end
      chk("latency1_busy_cycles", 32'(n1), 32'(2));
      chk("latency15_busy_cycles", 32'(n15), 32'(16));

      waitn = 0;
      while (sb.size() != 0 && waitn < 20) begin
         @(posedge clk);
         waitn++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
